dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the core MEM stage (core_*) and an external master (ext_*, e.g. program loader / IO bridge).
- Memory-side ports map onto the data memory's address/data/wren/q; the memory has a registered read, so q is valid one cycle after the address.
- The core has priority. A starvation counter forces one external grant after MAX_BURST consecutive core wins while ext_req is waiting.
- Drives core_stall into the pipeline stall logic.

Parameters:
- ADDR_WIDTH, 9, memory word-address width.
- DATA_WIDTH, 32, data width (XLEN).
- MAX_BURST, 4, max consecutive core grants while ext_req is pending (valid 1..15).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- core_req  in  1  core access request (held until granted).
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  ADDR_WIDTH  core address.
- core_wdata  in  DATA_WIDTH  core write data.
- core_gnt  out  1  core access accepted this cycle.
- core_stall  out  1  core_req & ~core_gnt.
- core_rvalid  out  1  core read data valid.
- core_rdata  out  DATA_WIDTH  core read data.
- ext_req, ext_we, ext_addr, ext_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  external request; same semantics as core_*.
- ext_gnt  out  1  external access accepted this cycle.
- ext_rvalid  out  1  external read data valid.
- ext_rdata  out  DATA_WIDTH  external read data.
- mem_address  out  ADDR_WIDTH  to data memory address.
- mem_data  out  DATA_WIDTH  to data memory data.
- mem_wren  out  1  to data memory wren.
- mem_q  in  DATA_WIDTH  from data memory q.

Behaviour:
- Reset (reset=0, async) clears starve_cnt, rd_owner and rd_pend.
  - All outputs read 0 while reset is held: gnt, rvalid, rdata, mem_wren, mem_address, mem_data.
  - Any read in flight is dropped; no rvalid is issued after reset releases.
- Arbitration is combinational in the request cycle:
  - ext_win = ext_req & (~core_req | starve_cnt == MAX_BURST).
  - core_gnt = core_req & ~ext_win.
  - ext_gnt = ext_win.
  - At most one gnt is high per cycle.
- Memory drive:
  - The winner's addr/wdata drive mem_address/mem_data.
  - mem_wren = winner_we & (core_gnt | ext_gnt).
  - With no grant: mem_wren=0 and mem_address/mem_data=0.
- starve_cnt (4-bit, registered):
  - Increments when core_gnt & ext_req.
  - Clears when ext_gnt or ~ext_req.
  - Holds otherwise.
  - Saturates at MAX_BURST; never wraps.
- Read return:
  - A granted read (gnt & ~we) sets rd_pend=1 and rd_owner=winner at the clock edge.
  - In the next cycle, <owner>_rvalid=1 and <owner>_rdata=mem_q; the other rvalid stays 0.
  - rd_pend is rewritten every cycle, so back-to-back reads give rvalid on consecutive cycles. Read latency is exactly 1 cycle after gnt.
- Writes:
  - Take effect at the grant edge; no response strobe.
  - A read to the same address in the next cycle returns the new data.
- Request holding rule: a requester that does not see gnt keeps req/we/addr/wdata stable. The arbiter does not latch requests.
- rdata outputs: core_rdata/ext_rdata hold their last value when rvalid=0. Capture into output registers is required.
- Sequencing: there is no state machine beyond starve_cnt and the read tracker; arbitration is decided fresh every cycle.

Test Plan:
- Reset then idle: reset=0 mid-read (core read granted, reset asserted next cycle) -> no core_rvalid after release; all outputs 0.
- Core only: core write addr 0x010 data 0xDEADBEEF, then read 0x010 -> core_gnt both cycles, core_rvalid one cycle after the read with core_rdata=0xDEADBEEF, core_stall=0 throughout.
- Ext only: ext read addr 0x1FF after preload 0x12345678 -> ext_gnt same cycle, ext_rvalid next cycle with 0x12345678, core_rvalid stays 0.
- Contention, MAX_BURST=4: core_req and ext_req held continuously -> grant pattern C,C,C,C,E,C,C,C,C,E; core_stall=1 exactly on the E cycles.
- Counter clear: ext_req drops after 2 core wins, then reasserts -> starve_cnt restarts from 0, so ext waits 4 more core grants.
- Back-to-back interleave: core read A (0x004 = 0x11), then ext read B (0x008 = 0x22) on consecutive cycles -> core_rvalid/0x11 then ext_rvalid/0x22 on consecutive cycles, never both high at once.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares a single-port data memory (registered read, q valid one cycle
//   after the address) between the core MEM stage and an external master.
//   The core has priority. A starvation counter hands one grant to the
//   external master after MAX_BURST consecutive core wins while ext_req waits.
//
// Ports
//   clock, reset                  : rising-edge clock, async active-low reset
//   core_req/we/addr/wdata        : core request, held until core_gnt
//   core_gnt, core_stall          : core accepted / core blocked this cycle
//   core_rvalid, core_rdata       : core read return, data held between strobes
//   ext_req/we/addr/wdata         : external request, same semantics as core
//   ext_gnt                       : external accepted this cycle
//   ext_rvalid, ext_rdata         : external read return, data held between strobes
//   mem_address/data/wren         : drive to data memory
//   mem_q                         : registered read data from data memory
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_gnt,
  output logic                  core_stall,
  output logic                  core_rvalid,
  output logic [DATA_WIDTH-1:0] core_rdata,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  output logic                  ext_gnt,
  output logic                  ext_rvalid,
  output logic [DATA_WIDTH-1:0] ext_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  logic                  core_req_v;
  logic                  ext_req_v;
  logic                  ext_win;
  logic [3:0]            starve_cnt_q, starve_cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_owner_q, rd_owner_d;
  logic [DATA_WIDTH-1:0] core_rdata_q, ext_rdata_q;

  // Requests are masked while reset is held so that every output, including
  // the combinational grants and memory drive, reads zero during reset.
  always_comb begin
    core_req_v   = core_req & reset;
    ext_req_v    = ext_req & reset;
    ext_win      = ext_req_v & (~core_req_v | (starve_cnt_q == MaxBurst));
    core_gnt     = core_req_v & ~ext_win;
    ext_gnt      = ext_win;
    core_stall   = core_req_v & ~core_gnt;

    mem_address  = '0;
    mem_data     = '0;
    mem_wren     = 1'b0;
    if (core_gnt) begin
      mem_address = core_addr;
      mem_data    = core_wdata;
      mem_wren    = core_we;
    end else if (ext_gnt) begin
      mem_address = ext_addr;
      mem_data    = ext_wdata;
      mem_wren    = ext_we;
    end

    // Counter tracks core wins while ext is waiting; it saturates, and at
    // MaxBurst ext always wins, which clears it on the next edge.
    starve_cnt_d = starve_cnt_q;
    if (ext_gnt || !ext_req_v) begin
      starve_cnt_d = '0;
    end else if (core_gnt && (starve_cnt_q != MaxBurst)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    // Rewritten every cycle so back-to-back reads return on consecutive cycles.
    rd_pend_d  = (core_gnt & ~core_we) | (ext_gnt & ~ext_we);
    rd_owner_d = ext_gnt;
  end

  // Return data passes mem_q straight through in the strobe cycle and the
  // capture register holds it afterwards.
  always_comb begin
    core_rvalid = rd_pend_q & ~rd_owner_q;
    ext_rvalid  = rd_pend_q & rd_owner_q;
    core_rdata  = core_rvalid ? mem_q : core_rdata_q;
    ext_rdata   = ext_rvalid ? mem_q : ext_rdata_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= '0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
      core_rdata_q <= '0;
      ext_rdata_q  <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
      if (core_rvalid) core_rdata_q <= mem_q;
      if (ext_rvalid)  ext_rdata_q  <= mem_q;
    end
  end

endmodule
